// File: rtl/QuplsPkg.sv
// Shared decode definitions for the functional-unit selector.
// Provides the instruction layout, opcode/function codes, the 4-bit
// functional-unit class vector with its bit indices, and fnIsAlu.
package QuplsPkg;

  localparam int unsigned NCLS    = 4;
  localparam int unsigned CLS_ALU = 0;
  localparam int unsigned CLS_FPU = 1;
  localparam int unsigned CLS_MEM = 2;
  localparam int unsigned CLS_FC  = 3;

  // Multi-hot functional-unit class, indexed by CLS_*.
  typedef logic [NCLS-1:0] fu_cls_t;

  localparam logic [6:0] OP_NOP  = 7'h00;
  localparam logic [6:0] OP_R2   = 7'h02;
  localparam logic [6:0] OP_ADDI = 7'h04;
  localparam logic [6:0] OP_ANDI = 7'h08;
  localparam logic [6:0] OP_ORI  = 7'h09;
  localparam logic [6:0] OP_FLT3 = 7'h0C;
  localparam logic [6:0] OP_Bcc  = 7'h20;
  localparam logic [6:0] OP_BccU = 7'h21;
  localparam logic [6:0] OP_BSR  = 7'h22;
  localparam logic [6:0] OP_JSR  = 7'h23;
  localparam logic [6:0] OP_RTD  = 7'h24;
  localparam logic [6:0] OP_LDx  = 7'h40;
  localparam logic [6:0] OP_LDxU = 7'h41;
  localparam logic [6:0] OP_STx  = 7'h48;

  localparam logic [5:0] FN_FADD = 6'h04;
  localparam logic [5:0] FN_FABS = 6'h10;
  localparam logic [5:0] FN_FNEG = 6'h11;
  localparam logic [5:0] FN_FMOV = 6'h12;

  typedef struct packed {
    logic [3:0] cond;
    logic [4:0] inc;
  } br_t;

  typedef struct packed {
    logic [5:0] func;
    logic [9:0] imm;
    br_t        br;
    logic [6:0] opcode;
  } instruction_t;

  // True when the instruction needs an ALU. Sign-only float ops run on the
  // ALU, and a branch with a nonzero increment needs an ALU for the add.
  function automatic logic fnIsAlu(input instruction_t ins);
    logic alu;
    alu = 1'b0;
    case (ins.opcode)
      OP_NOP, OP_R2, OP_ADDI, OP_ANDI, OP_ORI: alu = 1'b1;
      OP_FLT3: alu = (ins.func == FN_FABS) || (ins.func == FN_FNEG) ||
                     (ins.func == FN_FMOV);
      OP_Bcc, OP_BccU: alu = (ins.br.inc != 5'd0);
      default: alu = 1'b0;
    endcase
    return alu;
  endfunction

endpackage

// File: rtl/qupls_fu_classify_lane.sv
// Combinational classifier for one decode lane.
// Ports: ins   - instruction in this lane
//        cls_c - multi-hot functional-unit class (ALU/FPU/MEM/FC)
module qupls_fu_classify_lane
  import QuplsPkg::*;
(
  input  instruction_t ins,
  output fu_cls_t      cls_c
);

  logic alu_c;
  logic unused_c;

  assign unused_c = ^{ins.imm, ins.br.cond};

  // FPU only for float ops the ALU cannot handle; branches may be ALU|FC.
  always_comb begin
    cls_c          = '0;
    alu_c          = fnIsAlu(ins);
    cls_c[CLS_ALU] = alu_c;
    case (ins.opcode)
      OP_Bcc, OP_BccU, OP_BSR, OP_JSR, OP_RTD: cls_c[CLS_FC]  = 1'b1;
      OP_FLT3:                                 cls_c[CLS_FPU] = ~alu_c;
      OP_LDx, OP_LDxU, OP_STx:                 cls_c[CLS_MEM] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/qupls_decode_fu_sel.sv
// Decode-stage functional-unit selector: classifies each lane of a bundle,
// steers ALU lanes round-robin across NALU ALUs, and buffers results in a
// 2-entry skid buffer (output register + skid register), latency 1.
// Ports: clk, rst_n (async active-low), flush,
//        in_valid/in_ready/instr     - incoming bundle handshake
//        out_valid/out_ready         - outgoing bundle handshake
//        out_cls, out_alu_sel        - per-lane class and ALU instance
//        stat_cnt                    - per-class lane counts (only with
//                                      QUPLS_FU_STATS_EN defined)
module qupls_decode_fu_sel
  import QuplsPkg::*;
#(
  parameter  int unsigned LANES = 4,
  parameter  int unsigned NALU  = 2,
  localparam int unsigned SELW  = (NALU > 1) ? $clog2(NALU) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  instruction_t [LANES-1:0]     instr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output fu_cls_t [LANES-1:0]          out_cls,
  output logic [LANES-1:0][SELW-1:0]   out_alu_sel
`ifdef QUPLS_FU_STATS_EN
  ,
  output logic [NCLS-1:0][31:0]        stat_cnt
`endif
);

  localparam int unsigned CNTW = $clog2(LANES + 1);

  fu_cls_t [LANES-1:0]         cls_c;
  logic [LANES-1:0][SELW-1:0]  sel_c;
  logic [CNTW-1:0]             pre_c [LANES+1];
  logic [SELW-1:0]             rr_nxt_c;
  logic                        accept_c;
  logic                        pop_c;

  logic                        ov_q, ov_d;
  logic                        skid_empty_q, skid_empty_d;
  fu_cls_t [LANES-1:0]         ocls_q, ocls_d, scls_q, scls_d;
  logic [LANES-1:0][SELW-1:0]  osel_q, osel_d, ssel_q, ssel_d;
  logic [SELW-1:0]             rr_ptr, rr_d;

  // Per-lane classification and prefix count of ALU lanes below each lane.
  assign pre_c[0] = '0;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    qupls_fu_classify_lane u_cls (
      .ins   (instr[g]),
      .cls_c (cls_c[g])
    );
    assign pre_c[g+1] = pre_c[g] + CNTW'(cls_c[g][CLS_ALU]);
    assign sel_c[g]   = cls_c[g][CLS_ALU] ?
                        SELW'((32'(rr_ptr) + 32'(pre_c[g])) % NALU) : '0;
  end

  assign rr_nxt_c = SELW'((32'(rr_ptr) + 32'(pre_c[LANES])) % NALU);
  assign accept_c = in_valid & skid_empty_q & ~flush;
  assign pop_c    = ov_q & out_ready;

  // Skid-buffer next state; a pending skid entry always drains before new input.
  always_comb begin
    ov_d         = ov_q;
    skid_empty_d = skid_empty_q;
    ocls_d       = ocls_q;
    osel_d       = osel_q;
    scls_d       = scls_q;
    ssel_d       = ssel_q;
    rr_d         = rr_ptr;
    if (flush) begin
      ov_d         = 1'b0;
      skid_empty_d = 1'b1;
      rr_d         = '0;
    end else begin
      if (accept_c) rr_d = rr_nxt_c;
      if (!ov_q || pop_c) begin
        if (!skid_empty_q) begin
          ocls_d       = scls_q;
          osel_d       = ssel_q;
          skid_empty_d = 1'b1;
          ov_d         = 1'b1;
        end else if (accept_c) begin
          ocls_d = cls_c;
          osel_d = sel_c;
          ov_d   = 1'b1;
        end else begin
          ov_d = 1'b0;
        end
      end else if (accept_c) begin
        scls_d       = cls_c;
        ssel_d       = sel_c;
        skid_empty_d = 1'b0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q         <= 1'b0;
      skid_empty_q <= 1'b1;
      ocls_q       <= '0;
      osel_q       <= '0;
      scls_q       <= '0;
      ssel_q       <= '0;
      rr_ptr       <= '0;
    end else begin
      ov_q         <= ov_d;
      skid_empty_q <= skid_empty_d;
      ocls_q       <= ocls_d;
      osel_q       <= osel_d;
      scls_q       <= scls_d;
      ssel_q       <= ssel_d;
      rr_ptr       <= rr_d;
    end
  end

  assign in_ready    = skid_empty_q;
  assign out_valid   = ov_q;
  assign out_cls     = ocls_q;
  assign out_alu_sel = osel_q;

`ifdef QUPLS_FU_STATS_EN
  // Saturating per-class lane counters over bundles delivered downstream.
  for (genvar c = 0; c < NCLS; c++) begin : g_stat
    logic [CNTW-1:0] n_c [LANES+1];
    logic [32:0]     sum_c;
    logic [31:0]     cnt_q;

    assign n_c[0] = '0;
    for (genvar l = 0; l < LANES; l++) begin : g_l
      assign n_c[l+1] = n_c[l] + CNTW'(ocls_q[l][c]);
    end
    assign sum_c = {1'b0, cnt_q} + 33'(n_c[LANES]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     cnt_q <= '0;
      else if (pop_c) cnt_q <= sum_c[32] ? 32'hFFFF_FFFF : sum_c[31:0];
    end

    assign stat_cnt[c] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_qupls_decode_fu_sel.sv
// Self-checking bench for qupls_decode_fu_sel: one instance with default
// parameters (LANES=4, NALU=2) and one with NALU=3 for round-robin wrap.
module tb_qupls_decode_fu_sel;
  import QuplsPkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                    flush, in_valid, in_ready, out_valid, out_ready;
  instruction_t [3:0]      instr;
  fu_cls_t [3:0]           out_cls;
  logic [3:0][0:0]         out_alu_sel;

  logic                    flush3, in_valid3, in_ready3, out_valid3, out_ready3;
  instruction_t [3:0]      instr3;
  fu_cls_t [3:0]           out_cls3;
  logic [3:0][1:0]         out_alu_sel3;

`ifdef QUPLS_FU_STATS_EN
  logic [3:0][31:0]        stat_cnt, stat_cnt3;
`endif

  qupls_decode_fu_sel #(.LANES(4), .NALU(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .instr(instr), .out_valid(out_valid),
    .out_ready(out_ready), .out_cls(out_cls), .out_alu_sel(out_alu_sel)
`ifdef QUPLS_FU_STATS_EN
    , .stat_cnt(stat_cnt)
`endif
  );

  qupls_decode_fu_sel #(.LANES(4), .NALU(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush3), .in_valid(in_valid3),
    .in_ready(in_ready3), .instr(instr3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_cls(out_cls3), .out_alu_sel(out_alu_sel3)
`ifdef QUPLS_FU_STATS_EN
    , .stat_cnt(stat_cnt3)
`endif
  );

  localparam fu_cls_t A = 4'b0001;
  localparam fu_cls_t F = 4'b0010;
  localparam fu_cls_t M = 4'b0100;
  localparam fu_cls_t C = 4'b1000;
  localparam fu_cls_t Z = 4'b0000;
  localparam logic [6:0] OP_UNDEF  = 7'h7F;
  localparam logic [6:0] OP_UNDEF2 = 7'h55;
  localparam int NV = 7;

  typedef struct {
    instruction_t [3:0] ins;
    fu_cls_t [3:0]      cls;
    logic [3:0]         sel;
  } vec_t;

  vec_t vecs [NV];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic instruction_t mk(input logic [6:0] op, input logic [5:0] fn,
                                      input logic [4:0] inc);
    instruction_t i;
    i           = '0;
    i.opcode    = op;
    i.func      = fn;
    i.br.inc    = inc;
    return i;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  instruction_t [3:0] b_a, b_b, b_c, b_alu4, b_alu1, b_alu2;
  logic [1:0] exp_rr3 [4];
  logic [7:0] exp_sel3 [4];

  initial begin
    flush = 0; in_valid = 0; out_ready = 1; instr = '0;
    flush3 = 0; in_valid3 = 0; out_ready3 = 1; instr3 = '0;

    // Lane 0 is the rightmost element of each concatenation.
    vecs[0].ins = {mk(OP_NOP,6'h0,5'h0), mk(OP_Bcc,6'h0,5'h0),
                   mk(OP_FLT3,FN_FABS,5'h0), mk(OP_ADDI,6'h0,5'h0)};
    vecs[0].cls = {A, C, A, A};      vecs[0].sel = 4'b0010;
    vecs[1].ins = {mk(OP_STx,6'h0,5'h0), mk(OP_LDx,6'h0,5'h0),
                   mk(OP_ADDI,6'h0,5'h0), mk(OP_Bcc,6'h0,5'h2)};
    vecs[1].cls = {M, M, A, A|C};    vecs[1].sel = 4'b0010;
    vecs[2].ins = {mk(OP_ANDI,6'h0,5'h0), mk(OP_UNDEF,6'h0,5'h0),
                   mk(OP_ADDI,6'h0,5'h0), mk(OP_UNDEF,6'h0,5'h0)};
    vecs[2].cls = {A, Z, A, Z};      vecs[2].sel = 4'b1000;
    vecs[3].ins = {mk(OP_BccU,6'h0,5'h1), mk(OP_BccU,6'h0,5'h0),
                   mk(OP_RTD,6'h0,5'h0), mk(OP_JSR,6'h0,5'h0)};
    vecs[3].cls = {A|C, C, C, C};    vecs[3].sel = 4'b0000;
    vecs[4].ins = {mk(OP_R2,6'h0,5'h0), mk(OP_ADDI,6'h0,5'h0),
                   mk(OP_ANDI,6'h0,5'h0), mk(OP_ORI,6'h0,5'h0)};
    vecs[4].cls = {A, A, A, A};      vecs[4].sel = 4'b1010;
    vecs[5].ins = {mk(OP_ADDI,6'h0,5'h0), mk(OP_LDxU,6'h0,5'h0),
                   mk(OP_FLT3,FN_FADD,5'h0), mk(OP_FLT3,FN_FNEG,5'h0)};
    vecs[5].cls = {A, M, F, A};      vecs[5].sel = 4'b1000;
    vecs[6].ins = {mk(OP_Bcc,6'h0,5'h1F), mk(OP_UNDEF2,6'h0,5'h0),
                   mk(OP_FLT3,FN_FMOV,5'h0), mk(OP_BSR,6'h0,5'h0)};
    vecs[6].cls = {A|C, Z, A, C};    vecs[6].sel = 4'b1000;

    b_a = {mk(OP_UNDEF,6'h0,5'h0), mk(OP_UNDEF,6'h0,5'h0),
           mk(OP_NOP,6'h0,5'h0), mk(OP_ADDI,6'h0,5'h0)};
    b_b = {mk(OP_JSR,6'h0,5'h0), mk(OP_STx,6'h0,5'h0),
           mk(OP_ADDI,6'h0,5'h0), mk(OP_LDx,6'h0,5'h0)};
    b_c = {4{mk(OP_FLT3,FN_FADD,5'h0)}};
    b_alu4 = {4{mk(OP_ADDI,6'h0,5'h0)}};
    b_alu1 = {mk(OP_UNDEF,6'h0,5'h0), mk(OP_UNDEF,6'h0,5'h0),
              mk(OP_UNDEF,6'h0,5'h0), mk(OP_ADDI,6'h0,5'h0)};
    b_alu2 = {mk(OP_UNDEF,6'h0,5'h0), mk(OP_UNDEF,6'h0,5'h0),
              mk(OP_ADDI,6'h0,5'h0), mk(OP_ADDI,6'h0,5'h0)};
    exp_rr3  = '{2'd0, 2'd1, 2'd2, 2'd0};
    exp_sel3 = '{8'h24, 8'h49, 8'h92, 8'h24};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_cls", 64'(out_cls), 64'd0);
    chk("rst alu_sel", 64'(out_alu_sel), 64'd0);
    chk("rst rr_ptr", 64'(dut.rr_ptr), 64'd0);
    chk("rst out_valid3", 64'(out_valid3), 64'd0);
    rst_n = 1;

    // Single-bundle classification table, flushing between entries.
    for (int k = 0; k < NV; k++) begin
      instr = vecs[k].ins; in_valid = 1;
      @(negedge clk);
      in_valid = 0;
      chk($sformatf("v%0d valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d cls", k), 64'(out_cls), 64'(vecs[k].cls));
      chk($sformatf("v%0d sel", k), 64'(out_alu_sel), 64'(vecs[k].sel));
      flush = 1;
      @(negedge clk);
      flush = 0;
    end

    // Backpressure: two bundles held, then in-order release.
    out_ready = 0; in_valid = 1; instr = b_a;
    chk("bp rdy0", 64'(in_ready), 64'd1);
    @(negedge clk); instr = b_b;
    chk("bp valid1", 64'(out_valid), 64'd1);
    chk("bp rdy1", 64'(in_ready), 64'd1);
    @(negedge clk); instr = b_c;
    chk("bp rdy2", 64'(in_ready), 64'd0);
    chk("bp clsA", 64'(out_cls), 64'({Z, Z, A, A}));
    @(negedge clk);
    chk("bp rdy3", 64'(in_ready), 64'd0);
    chk("bp stable", 64'(out_cls), 64'({Z, Z, A, A}));
    chk("bp valid3", 64'(out_valid), 64'd1);
    out_ready = 1;
    @(negedge clk);
    chk("rel clsB", 64'(out_cls), 64'({C, M, A, M}));
    chk("rel validB", 64'(out_valid), 64'd1);
    chk("rel rdyB", 64'(in_ready), 64'd1);
    @(negedge clk); in_valid = 0;
    chk("rel clsC", 64'(out_cls), 64'({F, F, F, F}));
    chk("rel validC", 64'(out_valid), 64'd1);
    @(negedge clk);
    chk("rel empty", 64'(out_valid), 64'd0);

    // Flush with a full buffer and a pending input (rr_ptr is 1 beforehand).
    out_ready = 0; in_valid = 1; instr = b_b;
    @(negedge clk);
    @(negedge clk);
    chk("fl full rdy", 64'(in_ready), 64'd0);
    chk("fl pre rr", 64'(dut.rr_ptr), 64'd1);
    flush = 1; instr = b_c;
    @(negedge clk);
    flush = 0; in_valid = 0;
    chk("fl valid", 64'(out_valid), 64'd0);
    chk("fl rdy", 64'(in_ready), 64'd1);
    chk("fl rr", 64'(dut.rr_ptr), 64'd0);
    @(negedge clk);
    chk("fl dropped", 64'(out_valid), 64'd0);

    // Flush wins over an accept that has room.
    in_valid = 1; instr = b_b;
    @(negedge clk);
    flush = 1; instr = b_a;
    chk("fw rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    flush = 0; in_valid = 0;
    chk("fw valid", 64'(out_valid), 64'd0);
    chk("fw rr", 64'(dut.rr_ptr), 64'd0);
    @(negedge clk);
    chk("fw dropped", 64'(out_valid), 64'd0);

    // Reset mid-transfer, then accept on the first edge after release.
    in_valid = 1; instr = b_a;
    @(negedge clk); instr = b_b;
    @(negedge clk); in_valid = 0;
    chk("mr full", 64'(in_ready), 64'd0);
    rst_n = 0;
    #1;
    chk("mr valid", 64'(out_valid), 64'd0);
    chk("mr rdy", 64'(in_ready), 64'd1);
    chk("mr cls", 64'(out_cls), 64'd0);
    chk("mr sel", 64'(out_alu_sel), 64'd0);
    @(negedge clk);
    rst_n = 1; in_valid = 1; instr = b_c; out_ready = 1;
    @(negedge clk); in_valid = 0;
    chk("mr first valid", 64'(out_valid), 64'd1);
    chk("mr first cls", 64'(out_cls), 64'({F, F, F, F}));
    @(negedge clk);
    chk("mr no stale", 64'(out_valid), 64'd0);

    // NALU=3 round-robin over consecutive all-ALU bundles.
    in_valid3 = 1; instr3 = b_alu4;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr3 ptr%0d", k), 64'(dut3.rr_ptr), 64'(exp_rr3[k]));
      @(negedge clk);
      chk($sformatf("rr3 valid%0d", k), 64'(out_valid3), 64'd1);
      chk($sformatf("rr3 lane0 sel%0d", k), 64'(out_alu_sel3[0]), 64'(exp_rr3[k]));
      chk($sformatf("rr3 sel%0d", k), 64'(out_alu_sel3), 64'(exp_sel3[k]));
    end
    instr3 = b_alu1;
    chk("rr3 ptr4", 64'(dut3.rr_ptr), 64'd1);
    @(negedge clk);
    chk("rr3 one sel", 64'(out_alu_sel3), 64'h01);
    instr3 = b_alu2;
    chk("rr3 ptr5", 64'(dut3.rr_ptr), 64'd2);
    @(negedge clk);
    in_valid3 = 0;
    chk("rr3 wrap sel", 64'(out_alu_sel3), 64'h02);
    chk("rr3 wrap ptr", 64'(dut3.rr_ptr), 64'd1);
    @(negedge clk);

`ifdef QUPLS_FU_STATS_EN
    // ALU counter saturates instead of wrapping.
    force dut.g_stat[0].cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.g_stat[0].cnt_q;
    in_valid = 1; instr = b_a;
    @(negedge clk); in_valid = 0;
    @(negedge clk);
    chk("stat sat1", 64'(stat_cnt[0]), 64'hFFFF_FFFF);
    in_valid = 1; instr = b_a;
    @(negedge clk); in_valid = 0;
    @(negedge clk);
    chk("stat sat2", 64'(stat_cnt[0]), 64'hFFFF_FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qupls_decode_fu_sel.md
QUPLS_DECODE_FU_SEL -- requirements
Module: qupls_decode_fu_sel

Interface
REQ-001 SHALL have parameter LANES, default 4, the number of instructions per decode bundle (1..8).
REQ-002 SHALL have parameter NALU, default 2, the number of ALU instances steered across (1..4).
REQ-003 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port flush, input, 1 bit: discard all buffered bundles.
REQ-006 SHALL have port in_valid, input, 1 bit: the incoming bundle is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept a bundle.
REQ-008 SHALL have port instr, input, LANES x instruction_t: the instruction bundle.
REQ-009 SHALL have port out_valid, output, 1 bit: the classified bundle is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the bundle.
REQ-011 SHALL have port out_cls, output, LANES x fu_cls_t (4 bits: ALU, FPU, MEM, FC): multi-hot class per lane.
REQ-012 SHALL have port out_alu_sel, output, LANES x $clog2(NALU) bits (minimum 1): ALU instance per lane.

Function
REQ-013 SHALL set the ALU bit for a lane when the package function fnIsAlu is true, including Bcc/BccU with nonzero br.inc.
REQ-014 SHALL set the FC bit for OP_Bcc, OP_BccU, OP_BSR, OP_JSR and OP_RTD; Bcc with nonzero inc SHALL be both ALU and FC.
REQ-015 SHALL set the FPU bit for OP_FLT3 when the ALU bit is clear; load/store opcodes SHALL set MEM.
REQ-016 SHALL give an all-zero out_cls for an unclassified opcode; such a lane SHALL NOT consume an ALU slot.
REQ-017 SHALL accept a bundle on the cycle in_valid and in_ready are both 1, and SHALL present it on out_valid the next cycle (latency 1).
REQ-018 SHALL buffer bundles in a 2-entry skid buffer (output register plus skid register); in_ready SHALL be 1 when the skid register is empty.
REQ-019 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, with accept and out_ready on the same cycle, move the pending skid entry, or else the new bundle, into the output register with no bubble.
REQ-021 SHALL compute out_alu_sel[i] = (rr_ptr + number of ALU lanes below i) mod NALU.
REQ-022 SHALL, on accept, advance rr_ptr by the bundle's ALU-lane count mod NALU; wrap-around SHALL be exact (e.g. NALU=3, ptr=2, +2 gives 1).
REQ-023 SHALL, on flush, clear both buffer entries and set rr_ptr=0 the next cycle; flush SHALL win over a simultaneous accept, and that input SHALL be dropped.
REQ-024 SHALL give out_alu_sel=0 for lanes without the ALU bit.

Reset
REQ-025 SHALL, while rst_n=0, hold out_valid=0, in_ready=1, out_cls=0, out_alu_sel=0, rr_ptr=0, skid empty.
REQ-026 SHALL, on reset mid-transfer, discard buffered bundles; first accept SHALL be possible on the first clock edge after rst_n rises.

Configuration
REQ-027 SHALL, with QUPLS_FU_STATS_EN defined, add output stat_cnt (4 x 32 bits): per-class saturating counts of lanes in bundles accepted downstream (out_valid and out_ready), cleared by reset only.
REQ-028 SHALL, without QUPLS_FU_STATS_EN, omit the stat_cnt port and its counters; all other behaviour SHALL be identical.

Structure
REQ-029 SHALL define fu_cls_t, the class bit indices and the fnIsAlu function in QuplsPkg.
REQ-030 SHALL place per-lane classification in one combinational sub-module qupls_fu_classify_lane, instantiated LANES times; this module holds the skid buffer and rr_ptr.

Verification
REQ-031 SHALL test: reset, then one bundle {ADDI, FLT3 FABS, Bcc inc=0, NOP} -> one cycle later out_cls ALU, ALU, FC, ALU; alu_sel 0, 1, 0, 0.
REQ-032 SHALL test: NALU=3, four consecutive all-ALU bundles (LANES=4) -> rr_ptr 0, 1, 2, 0; first lane alu_sel of each bundle 0, 1, 2, 0.
REQ-033 SHALL test: out_ready=0 for 3 cycles with in_valid=1 -> two bundles held, in_ready=0 after the second; release -> in-order delivery, no loss or duplicate.
REQ-034 SHALL test: flush asserted with in_valid=1 and buffer full -> next cycle out_valid=0, in_ready=1, rr_ptr=0, input dropped.
REQ-035 SHALL test: Bcc with inc=2 -> out_cls = ALU|FC, and it consumes one ALU slot.
REQ-036 SHALL test: with QUPLS_FU_STATS_EN, ALU counter preset near 32'hFFFFFFFF and two ALU lanes accepted -> holds 32'hFFFFFFFF.
